// File: rtl/serv_bus_arb.sv
// serv_bus_arb: merges the SERV instruction and data buses onto one registered memory-side port.
// Optional watchdog is built when SERV_BUS_ARB_TIMEOUT_EN is defined.
module serv_bus_arb #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        last_d_r;
  logic        last_d_next_s;
  logic        gnt_d_r;
  logic        gnt_d_next_s;
  logic        pick_d_s;
  logic        tmo_s;
  logic        done_s;
  logic [31:0] rdt_sel_s;
  logic [31:0] wb_adr_next_s;
  logic [31:0] wb_dat_next_s;
  logic [3:0]  wb_sel_next_s;
  logic        wb_we_next_s;
  logic        wb_cyc_next_s;
  logic [31:0] ibus_rdt_next_s;
  logic        ibus_ack_next_s;
  logic [31:0] dbus_rdt_next_s;
  logic        dbus_ack_next_s;

  // Tie-break: a lone requester wins, otherwise the master not served last.
  always_comb begin
    if (i_ibus_cyc && i_dbus_cyc) begin
      pick_d_s = ~last_d_r;
    end else begin
      pick_d_s = i_dbus_cyc;
    end
  end

  assign done_s    = i_wb_ack | tmo_s;
  assign rdt_sel_s = i_wb_ack ? i_wb_rdt : 32'h0000_0000;

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_next_s    = state_r;
    last_d_next_s   = last_d_r;
    gnt_d_next_s    = gnt_d_r;
    wb_adr_next_s   = o_wb_adr;
    wb_dat_next_s   = o_wb_dat;
    wb_sel_next_s   = o_wb_sel;
    wb_we_next_s    = o_wb_we;
    wb_cyc_next_s   = o_wb_cyc;
    ibus_rdt_next_s = o_ibus_rdt;
    ibus_ack_next_s = 1'b0;
    dbus_rdt_next_s = o_dbus_rdt;
    dbus_ack_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_ibus_cyc || i_dbus_cyc) begin
          gnt_d_next_s  = pick_d_s;
          wb_cyc_next_s = 1'b1;
          state_next_s  = ST_GRANT;
          if (pick_d_s) begin
            wb_adr_next_s = i_dbus_adr;
            wb_dat_next_s = i_dbus_dat;
            wb_sel_next_s = i_dbus_sel;
            wb_we_next_s  = i_dbus_we;
          end else begin
            wb_adr_next_s = i_ibus_adr;
            wb_dat_next_s = 32'h0000_0000;
            wb_sel_next_s = 4'hF;
            wb_we_next_s  = 1'b0;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (done_s) begin
          wb_cyc_next_s = 1'b0;
          last_d_next_s = gnt_d_r;
          state_next_s  = ST_RELEASE;
          if (gnt_d_r) begin
            dbus_ack_next_s = 1'b1;
            dbus_rdt_next_s = rdt_sel_s;
          end else begin
            ibus_ack_next_s = 1'b1;
            ibus_rdt_next_s = rdt_sel_s;
          end
        end else begin
          state_next_s = ST_GRANT;
        end
      end
      ST_RELEASE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s  = ST_IDLE;
        wb_cyc_next_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight transfer.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      last_d_r   <= 1'b1;
      gnt_d_r    <= 1'b0;
      o_wb_adr   <= 32'h0000_0000;
      o_wb_dat   <= 32'h0000_0000;
      o_wb_sel   <= 4'h0;
      o_wb_we    <= 1'b0;
      o_wb_cyc   <= 1'b0;
      o_ibus_rdt <= 32'h0000_0000;
      o_ibus_ack <= 1'b0;
      o_dbus_rdt <= 32'h0000_0000;
      o_dbus_ack <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      last_d_r   <= last_d_next_s;
      gnt_d_r    <= gnt_d_next_s;
      o_wb_adr   <= wb_adr_next_s;
      o_wb_dat   <= wb_dat_next_s;
      o_wb_sel   <= wb_sel_next_s;
      o_wb_we    <= wb_we_next_s;
      o_wb_cyc   <= wb_cyc_next_s;
      o_ibus_rdt <= ibus_rdt_next_s;
      o_ibus_ack <= ibus_ack_next_s;
      o_dbus_rdt <= dbus_rdt_next_s;
      o_dbus_ack <= dbus_ack_next_s;
    end
  end

`ifdef SERV_BUS_ARB_TIMEOUT_EN
  // Counter value seen on the last unacked GRANT cycle before the watchdog fires.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((64'd1 << TIMEOUT_W) - 64'd2);

  logic [TIMEOUT_W-1:0] tmo_cnt_r;

  assign tmo_s = (state_r == ST_GRANT) && !i_wb_ack && (tmo_cnt_r == TMO_LAST);

  // Watchdog counter: zero outside GRANT, counts GRANT cycles.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt_r <= {TIMEOUT_W{1'b0}};
    end else if (state_r == ST_GRANT) begin
      tmo_cnt_r <= tmo_cnt_r + TIMEOUT_W'(1);
    end else begin
      tmo_cnt_r <= {TIMEOUT_W{1'b0}};
    end
  end

  // Sticky error flag set by a watchdog termination.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else begin
      o_err <= o_err | tmo_s;
    end
  end
`else
  logic [TIMEOUT_W-1:0] unused_tmo_s;

  assign unused_tmo_s = {TIMEOUT_W{1'b0}};
  assign tmo_s        = 1'b0;
  assign o_err        = 1'b0;
`endif

endmodule
